// File: rtl/pc_unit_pkg.sv
// rtl/pc_unit_pkg.sv - shared types for the fetch-stage program counter
// Contents: FSM state encoding (RUN/HALT/STEP) and next-PC mux select codes.
package pc_unit_pkg;

    // STEP is only reachable when PC_UNIT_STEP_EN is defined
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } state_t;

    // Next-PC source chosen by pc_next_sel
    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_SEQ    = 2'd1,
        SEL_BRANCH = 2'd2,
        SEL_JUMP   = 2'd3
    } sel_t;

endpackage

// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - control/status bundle between fetch control and pc_unit
// master: pipeline/debug side, drives select inputs and observes PC status.
// slave : pc_unit side.
// Optional macro PC_UNIT_STEP_EN adds i_step (single-step request while halted).
interface pc_unit_if #(
    parameter int NB     = 32,
    parameter int NB_CNT = 32
);
    logic              i_enable;
    logic              i_stall;
    logic              i_branch_taken;
    logic [NB-1:0]     i_branch_addr;
    logic              i_jump;
    logic [NB-1:0]     i_jump_addr;
    logic              i_halt;
    logic              i_resume;
`ifdef PC_UNIT_STEP_EN
    logic              i_step;
`endif
    logic [NB-1:0]     o_pc;
    logic [NB-1:0]     o_pc_inc;
    logic              o_halted;
    logic [NB_CNT-1:0] o_fetch_cnt;
    logic              o_misaligned;

    modport master (
        output i_enable, i_stall, i_branch_taken, i_branch_addr,
        output i_jump, i_jump_addr, i_halt, i_resume,
`ifdef PC_UNIT_STEP_EN
        output i_step,
`endif
        input  o_pc, o_pc_inc, o_halted, o_fetch_cnt, o_misaligned
    );

    modport slave (
        input  i_enable, i_stall, i_branch_taken, i_branch_addr,
        input  i_jump, i_jump_addr, i_halt, i_resume,
`ifdef PC_UNIT_STEP_EN
        input  i_step,
`endif
        output o_pc, o_pc_inc, o_halted, o_fetch_cnt, o_misaligned
    );
endinterface

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC priority mux with alignment mask
// Ports: pc (current PC), hold (FSM/enable freeze), redirect_en (branch/jump
// allowed), stall, branch_taken/branch_addr, jump/jump_addr -> next_pc,
// pc_inc (pc + INC, wrapping), sel (chosen source), misaligned (accepted
// redirect target had nonzero low bits).
module pc_next_sel
    import pc_unit_pkg::*;
#(
    parameter int NB  = 32,
    parameter int INC = 4
) (
    input  logic [NB-1:0] pc,
    input  logic          hold,
    input  logic          redirect_en,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [NB-1:0] branch_addr,
    input  logic          jump,
    input  logic [NB-1:0] jump_addr,
    output logic [NB-1:0] next_pc,
    output logic [NB-1:0] pc_inc,
    output sel_t          sel,
    output logic          misaligned
);
    // INC is a power of two, so INC-1 covers exactly the offset bits
    localparam logic [NB-1:0] LOW_MASK = NB'(INC - 1);

    logic [NB-1:0] target;

    assign pc_inc = pc + NB'(INC);

    always_comb begin
        sel        = SEL_SEQ;
        target     = jump_addr;
        next_pc    = pc_inc;
        misaligned = 1'b0;

        // Redirects are checked before stall: a taken branch/jump flushes
        // whatever caused the stall.
        if (hold) begin
            sel = SEL_HOLD;
        end else if (redirect_en && branch_taken) begin
            sel    = SEL_BRANCH;
            target = branch_addr;
        end else if (redirect_en && jump) begin
            sel    = SEL_JUMP;
            target = jump_addr;
        end else if (stall) begin
            sel = SEL_HOLD;
        end

        case (sel)
            SEL_HOLD: next_pc = pc;
            SEL_SEQ:  next_pc = pc_inc;
            default: begin
                next_pc    = target & ~LOW_MASK;
                misaligned = |(target & LOW_MASK);
            end
        endcase
    end
endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage PC register with next-PC select, HALT FSM and fetch counter
// Ports: i_clock (rising edge), i_reset (sync, active-low), bus (pc_unit_if.slave):
// enable/stall/branch/jump/halt/resume in; o_pc, o_pc_inc, o_halted,
// o_fetch_cnt, o_misaligned out.
// Optional macro PC_UNIT_STEP_EN: i_step in HALT enters STEP, which performs
// exactly one PC update (sequential or redirect) and returns to HALT.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int            NB           = 32,
    parameter int            INC          = 4,
    parameter logic [NB-1:0] RESET_VECTOR = '0,
    parameter int            NB_CNT       = 32
) (
    input  logic  i_clock,
    input  logic  i_reset,
    pc_unit_if.slave bus
);
    state_t            state, state_next;
    logic [NB-1:0]     pc, next_pc, pc_inc;
    logic [NB_CNT-1:0] fetch_cnt;
    logic              mis_q, mis_next;
    sel_t              sel;
    logic              hold, redirect_en, stall_use;
    logic              redirect, step_req;

    assign redirect = bus.i_branch_taken | bus.i_jump;

`ifdef PC_UNIT_STEP_EN
    assign step_req = bus.i_step;
`else
    assign step_req = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        hold        = 1'b1;
        redirect_en = 1'b0;
        stall_use   = 1'b0;
        if (bus.i_enable) begin
            case (state)
                RUN: begin
                    redirect_en = 1'b1;
                    stall_use   = bus.i_stall;
                    // HALT on a squashed path (redirect) or stalled is ignored;
                    // otherwise the PC parks on the HALT instruction.
                    hold        = bus.i_halt && !bus.i_stall && !redirect;
                    if (hold) begin
                        state_next = HALT;
                    end
                end
                HALT: begin
                    if (bus.i_resume) begin
                        hold       = 1'b0;
                        state_next = RUN;
                    end else if (step_req) begin
                        state_next = STEP;
                    end
                end
                STEP: begin
                    hold        = 1'b0;
                    redirect_en = 1'b1;
                    state_next  = HALT;
                end
                default: state_next = RUN;
            endcase
        end
    end

    pc_next_sel #(.NB(NB), .INC(INC)) u_sel (
        .pc          (pc),
        .hold        (hold),
        .redirect_en (redirect_en),
        .stall       (stall_use),
        .branch_taken(bus.i_branch_taken),
        .branch_addr (bus.i_branch_addr),
        .jump        (bus.i_jump),
        .jump_addr   (bus.i_jump_addr),
        .next_pc     (next_pc),
        .pc_inc      (pc_inc),
        .sel         (sel),
        .misaligned  (mis_next)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state     <= RUN;
            pc        <= RESET_VECTOR;
            fetch_cnt <= '0;
            mis_q     <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= next_pc;
            mis_q <= mis_next;
            if (sel != SEL_HOLD) begin
                fetch_cnt <= fetch_cnt + 1'b1;
            end
        end
    end

    assign bus.o_pc        = pc;
    assign bus.o_pc_inc    = pc_inc;
    assign bus.o_halted    = (state == HALT);
    assign bus.o_fetch_cnt = fetch_cnt;
    assign bus.o_misaligned = mis_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit (vector table + random vs model)
module tb_pc_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pc_unit_if #(.NB(32), .NB_CNT(32)) bus ();
    pc_unit_if #(.NB(32), .NB_CNT(32)) bus2 ();

    pc_unit #(.NB(32), .INC(4), .RESET_VECTOR(32'h0), .NB_CNT(32)) dut (
        .i_clock(clk), .i_reset(rst_n), .bus(bus)
    );
    pc_unit #(.NB(32), .INC(4), .RESET_VECTOR(32'h100), .NB_CNT(32)) dut_rv (
        .i_clock(clk), .i_reset(rst_n), .bus(bus2)
    );

    assign bus2.i_enable       = bus.i_enable;
    assign bus2.i_stall        = bus.i_stall;
    assign bus2.i_branch_taken = bus.i_branch_taken;
    assign bus2.i_branch_addr  = bus.i_branch_addr;
    assign bus2.i_jump         = bus.i_jump;
    assign bus2.i_jump_addr    = bus.i_jump_addr;
    assign bus2.i_halt         = bus.i_halt;
    assign bus2.i_resume       = bus.i_resume;
`ifdef PC_UNIT_STEP_EN
    assign bus2.i_step         = 1'b0;
`endif

    typedef struct {
        bit          rst_n, en, stall, br;
        logic [31:0] baddr;
        bit          jp;
        logic [31:0] jaddr;
        bit          halt, resume;
        logic [31:0] pc, cnt;
        bit          halted, mis;
    } vec_t;

    vec_t vecs[$];

    // reference model state
    logic [31:0] m_pc, m_cnt;
    bit          m_halted, m_mis;

    function automatic vec_t v(bit r, bit e, bit s, bit b, logic [31:0] ba, bit j,
                               logic [31:0] ja, bit h, bit rs, logic [31:0] p,
                               logic [31:0] c, bit hd, bit m);
        vec_t x;
        x.rst_n = r; x.en = e; x.stall = s; x.br = b; x.baddr = ba; x.jp = j;
        x.jaddr = ja; x.halt = h; x.resume = rs; x.pc = p; x.cnt = c;
        x.halted = hd; x.mis = m;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit s, input bit b,
                         input logic [31:0] ba, input bit j, input logic [31:0] ja,
                         input bit h, input bit rs);
        rst_n              = r;
        bus.i_enable       = e;
        bus.i_stall        = s;
        bus.i_branch_taken = b;
        bus.i_branch_addr  = ba;
        bus.i_jump         = j;
        bus.i_jump_addr    = ja;
        bus.i_halt         = h;
        bus.i_resume       = rs;
    endtask

    // Spec-level model: priority reset > freeze > halted > branch > jump > stall > halt > seq
    task automatic model_edge(input bit r, input bit e, input bit s, input bit b,
                              input logic [31:0] ba, input bit j, input logic [31:0] ja,
                              input bit h, input bit rs);
        logic [31:0] tgt;
        if (!r) begin
            m_pc = 32'h0; m_cnt = 0; m_halted = 0; m_mis = 0;
        end else if (!e) begin
            m_mis = 0;
        end else if (m_halted) begin
            m_mis = 0;
            if (rs) begin
                m_halted = 0; m_pc = m_pc + 4; m_cnt = m_cnt + 1;
            end
        end else if (b || j) begin
            tgt   = b ? ba : ja;
            m_mis = (tgt % 4) != 0;
            m_pc  = tgt - (tgt % 4);
            m_cnt = m_cnt + 1;
        end else begin
            m_mis = 0;
            if (s) begin
                // hold
            end else if (h) begin
                m_halted = 1;
            end else begin
                m_pc = m_pc + 4; m_cnt = m_cnt + 1;
            end
        end
    endtask

    initial begin
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef PC_UNIT_STEP_EN
        bus.i_step = 1'b0;
`endif
        //      rst en st br baddr        jp jaddr    hlt res  pc            cnt h  m
        vecs.push_back(v(0, 1, 0, 0, 0,            0, 0,       0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0,            0, 0,       0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0,            0, 0,       0, 0, 32'h4,        1, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0,            0, 0,       0, 0, 32'h8,        2, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0,            0, 0,       0, 0, 32'hC,        3, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 0,            0, 0,       0, 0, 32'hC,        3, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 0,            0, 0,       0, 0, 32'hC,        3, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0,            0, 0,       0, 0, 32'h10,       4, 0, 0));
        vecs.push_back(v(1, 1, 1, 1, 32'h40,       1, 32'h80,  0, 0, 32'h40,       5, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0,            0, 0,       0, 0, 32'h44,       6, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0,            1, 32'h23,  0, 0, 32'h20,       7, 0, 1));
        vecs.push_back(v(1, 1, 0, 0, 0,            0, 0,       0, 0, 32'h24,       8, 0, 0));
        vecs.push_back(v(1, 1, 0, 1, 32'h10,       0, 0,       0, 0, 32'h10,       9, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0,            0, 0,       1, 0, 32'h10,       9, 1, 0));
        vecs.push_back(v(1, 1, 0, 0, 0,            0, 0,       0, 0, 32'h10,       9, 1, 0));
        vecs.push_back(v(1, 1, 0, 0, 0,            0, 0,       0, 0, 32'h10,       9, 1, 0));
        vecs.push_back(v(1, 1, 0, 0, 0,            0, 0,       0, 0, 32'h10,       9, 1, 0));
        vecs.push_back(v(1, 1, 1, 1, 32'h80,       1, 32'hA0,  1, 0, 32'h10,       9, 1, 0));
        vecs.push_back(v(1, 1, 0, 0, 0,            0, 0,       0, 1, 32'h14,      10, 0, 0));
        vecs.push_back(v(1, 1, 0, 1, 32'h30,       0, 0,       1, 0, 32'h30,      11, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 0,            0, 0,       1, 0, 32'h30,      11, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0,            0, 0,       1, 0, 32'h30,      11, 1, 0));
        vecs.push_back(v(1, 0, 0, 0, 0,            0, 0,       0, 1, 32'h30,      11, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0,            0, 0,       1, 0, 32'h0,        0, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0,            0, 0,       0, 0, 32'h4,        1, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0,            1, 32'h21,  0, 0, 32'h4,        1, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0,            1, 32'h21,  0, 0, 32'h20,       2, 0, 1));
        vecs.push_back(v(1, 0, 0, 0, 0,            0, 0,       0, 0, 32'h20,       2, 0, 0));
        vecs.push_back(v(1, 1, 0, 1, 32'hFFFFFFFC, 0, 0,       0, 0, 32'hFFFFFFFC, 3, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0,            0, 0,       0, 0, 32'h0,        4, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].stall, vecs[i].br, vecs[i].baddr,
                  vecs[i].jp, vecs[i].jaddr, vecs[i].halt, vecs[i].resume);
            @(posedge clk); #1;
            chk($sformatf("vec%0d pc", i), {32'h0, bus.o_pc}, {32'h0, vecs[i].pc});
            chk($sformatf("vec%0d pc_inc", i), {32'h0, bus.o_pc_inc}, {32'h0, vecs[i].pc + 32'd4});
            chk($sformatf("vec%0d cnt", i), {32'h0, bus.o_fetch_cnt}, {32'h0, vecs[i].cnt});
            chk($sformatf("vec%0d halted", i), {63'h0, bus.o_halted}, {63'h0, vecs[i].halted});
            chk($sformatf("vec%0d misaligned", i), {63'h0, bus.o_misaligned}, {63'h0, vecs[i].mis});
            if (i == 1) begin
                chk("rv pc", {32'h0, bus2.o_pc}, 64'h100);
                chk("rv cnt", {32'h0, bus2.o_fetch_cnt}, 64'h0);
                chk("rv halted", {63'h0, bus2.o_halted}, 64'h0);
            end
            if (i == 2) chk("rv pc seq", {32'h0, bus2.o_pc}, 64'h104);
        end

        // randomized run against the model, starting from a reset
        m_pc = 0; m_cnt = 0; m_halted = 0; m_mis = 0;
        for (int i = 0; i < 1500; i++) begin
            bit r, e, s, b, j, h, rs;
            logic [31:0] ba, ja;
            r  = (i == 0) ? 1'b0 : ($urandom % 64 != 0);
            e  = ($urandom % 8 != 0);
            s  = ($urandom % 4 == 0);
            b  = ($urandom % 6 == 0);
            j  = ($urandom % 6 == 0);
            h  = ($urandom % 5 == 0);
            rs = ($urandom % 3 == 0);
            ba = $urandom;
            ja = $urandom;
            drive(r, e, s, b, ba, j, ja, h, rs);
            model_edge(r, e, s, b, ba, j, ja, h, rs);
            @(posedge clk); #1;
            chk("rnd pc", {32'h0, bus.o_pc}, {32'h0, m_pc});
            chk("rnd cnt", {32'h0, bus.o_fetch_cnt}, {32'h0, m_cnt});
            chk("rnd halted", {63'h0, bus.o_halted}, {63'h0, m_halted});
            chk("rnd misaligned", {63'h0, bus.o_misaligned}, {63'h0, m_mis});
        end

`ifdef PC_UNIT_STEP_EN
        // single step from HALT at 0x10: one advance to 0x14, then parked in HALT
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
        end
        drive(1, 1, 0, 0, 0, 0, 0, 1, 0);
        @(posedge clk); #1;
        chk("step halt pc", {32'h0, bus.o_pc}, 64'h10);
        chk("step halted", {63'h0, bus.o_halted}, 64'h1);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        bus.i_step = 1'b1;
        @(posedge clk); #1;
        bus.i_step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        chk("step pc", {32'h0, bus.o_pc}, 64'h14);
        chk("step cnt", {32'h0, bus.o_fetch_cnt}, 64'h5);
        chk("step rehalted", {63'h0, bus.o_halted}, 64'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
